// File: rtl/scan_capture.sv
// scan_capture: matrix-scanner frame grabber.
// Two input pipeline stages feed a capture FSM with registered pulses.
module scan_capture #(
   parameter int unsigned MAX_GAP = 4,
   parameter logic        ROW_INV = 1'b0
) (
   input  logic        fs,
   input  logic        rst,
   input  logic [7:0]  line,
   input  logic [7:0]  row,
   output logic [63:0] frame,
   output logic        frame_valid,
   output logic        seq_err,
   output logic        hot_err,
   output logic        gap_err,
   output logic [7:0]  frame_cnt
);

   localparam int GW = $clog2(MAX_GAP + 2);

   typedef enum logic {IDLE, CAPT} state_t;
   typedef enum logic [1:0] {C_BLANK, C_HOT, C_BAD} cls_t;

   logic [7:0]    line_q, row_q;
   cls_t          cls_d, cls_q;
   logic [2:0]    idx_d, idx_q;
   logic [7:0]    row2_q;
   logic [7:0]    wrow;

   state_t        state_d, state_q;
   logic [2:0]    exp_d, exp_q;
   logic [GW-1:0] gap_d, gap_q;
   logic [63:0]   shadow_d, shadow_q;
   logic [63:0]   frame_d, frame_q;
   logic [7:0]    fcnt_d, fcnt_q;
   logic          fv_d, fv_q;
   logic          seq_d, seq_q;
   logic          hot_d, hot_q;
   logic          gerr_d, gerr_q;

   // Stage 1: raw scanner sample
   always_ff @(posedge fs or posedge rst) begin
      if (rst) begin
         line_q <= '0;
         row_q  <= '0;
      end else begin
         line_q <= line;
         row_q  <= row;
      end
   end

   // Classify the sampled row-select and find its index
   always_comb begin
      idx_d = '0;
      for (int i = 0; i < 8; i++) begin
         if (line_q[i]) idx_d = 3'(i);
      end
      if (line_q == 8'h00)
         cls_d = C_BLANK;
      else if ($countones(line_q) == 1)
         cls_d = C_HOT;
      else
         cls_d = C_BAD;
   end

   // Stage 2: decoded line class, index and row
   always_ff @(posedge fs or posedge rst) begin
      if (rst) begin
         cls_q  <= C_BLANK;
         idx_q  <= '0;
         row2_q <= '0;
      end else begin
         cls_q  <= cls_d;
         idx_q  <= idx_d;
         row2_q <= row_q;
      end
   end

   assign wrow = ROW_INV ? ~row2_q : row2_q;

   // Capture FSM: next state, shadow/frame updates and pulses
   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      gap_d    = gap_q;
      shadow_d = shadow_q;
      frame_d  = frame_q;
      fcnt_d   = fcnt_q;
      fv_d     = 1'b0;
      seq_d    = 1'b0;
      hot_d    = 1'b0;
      gerr_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cls_q == C_HOT && idx_q == 3'd0) begin
               shadow_d[7:0] = wrow;
               exp_d   = 3'd1;
               gap_d   = '0;
               state_d = CAPT;
            end else if (cls_q == C_BAD) begin
               hot_d = 1'b1;
            end
         end
         CAPT: begin
            case (cls_q)
               C_HOT: begin
                  gap_d = '0;
                  if (idx_q == exp_q) begin
                     shadow_d[{exp_q, 3'b000} +: 8] = wrow;
                     if (exp_q == 3'd7) begin
                        frame_d = {wrow, shadow_q[55:0]};
                        fv_d    = 1'b1;
                        fcnt_d  = fcnt_q + 8'd1;
                        exp_d   = 3'd1;
                        state_d = IDLE;
                     end else begin
                        exp_d = exp_q + 3'd1;
                     end
                  end else begin
                     seq_d = 1'b1;
                     exp_d = 3'd1;
                     if (idx_q == 3'd0)
                        shadow_d[7:0] = wrow;
                     else
                        state_d = IDLE;
                  end
               end
               C_BAD: begin
                  hot_d   = 1'b1;
                  exp_d   = 3'd1;
                  gap_d   = '0;
                  state_d = IDLE;
               end
               default: begin
                  if (gap_q >= GW'(MAX_GAP)) begin
                     gerr_d  = 1'b1;
                     gap_d   = '0;
                     exp_d   = 3'd1;
                     state_d = IDLE;
                  end else begin
                     gap_d = gap_q + 1'b1;
                  end
               end
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state, shadow, frame and registered pulses
   always_ff @(posedge fs or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         exp_q    <= 3'd1;
         gap_q    <= '0;
         shadow_q <= '0;
         frame_q  <= '0;
         fcnt_q   <= '0;
         fv_q     <= 1'b0;
         seq_q    <= 1'b0;
         hot_q    <= 1'b0;
         gerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         gap_q    <= gap_d;
         shadow_q <= shadow_d;
         frame_q  <= frame_d;
         fcnt_q   <= fcnt_d;
         fv_q     <= fv_d;
         seq_q    <= seq_d;
         hot_q    <= hot_d;
         gerr_q   <= gerr_d;
      end
   end

   assign frame       = frame_q;
   assign frame_cnt   = fcnt_q;
   assign frame_valid = fv_q;
   assign seq_err     = seq_q;
   assign hot_err     = hot_q;
   assign gap_err     = gerr_q;

endmodule

// File: tb/tb_scan_capture.sv
// tb_scan_capture: directed scans with a pulse scoreboard.
// Expected pulses are queued at stimulus time and checked by a monitor.
`timescale 1ns/1ps
module tb_scan_capture;

   localparam logic [3:0] K_FV  = 4'b0001;
   localparam logic [3:0] K_SEQ = 4'b0010;
   localparam logic [3:0] K_HOT = 4'b0100;
   localparam logic [3:0] K_GAP = 4'b1000;

   localparam logic [63:0] F1 = 64'h817E4A3E3E4A7E81;
   localparam logic [63:0] F2 = 64'h1716151413121110;
   localparam logic [63:0] FX = 64'hAAAAAAAAAAAAAAAA;

   typedef struct {
      int         cyc;
      logic [3:0] kind;
      logic [63:0] frm;
      logic [7:0] cnt;
   } ev_t;

   logic        fs = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  line = '0;
   logic [7:0]  row = '0;
   logic [63:0] frame;
   logic        frame_valid, seq_err, hot_err, gap_err;
   logic [7:0]  frame_cnt;

   ev_t         sb[$];
   int          ncyc = 0;
   int          last = 0;
   int          nvec = 0;
   int          nbad = 0;
   bit          done = 1'b0;
   logic [63:0] efrm = '0;
   logic [7:0]  ecnt = '0;

   scan_capture #(.MAX_GAP(4), .ROW_INV(1'b0)) dut (
      .fs          (fs),
      .rst         (rst),
      .line        (line),
      .row         (row),
      .frame       (frame),
      .frame_valid (frame_valid),
      .seq_err     (seq_err),
      .hot_err     (hot_err),
      .gap_err     (gap_err),
      .frame_cnt   (frame_cnt)
   );

   initial forever #5 fs = ~fs;

   always @(posedge fs) ncyc <= ncyc + 1;

   task automatic drive(input logic [7:0] l, input logic [7:0] r);
      @(negedge fs);
      line = l;
      row  = r;
      last = ncyc;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(8'h00, 8'h00);
   endtask

   task automatic scan_part(input logic [63:0] f, input int lo, input int hi);
      logic [7:0] l;
      for (int k = lo; k <= hi; k++) begin
         l = 8'h01 << k;
         drive(l, f[8*k +: 8]);
      end
   endtask

   task automatic expect_ev(input logic [3:0] kind);
      sb.push_back('{last + 3, kind, efrm, ecnt});
   endtask

   task automatic complete(input logic [63:0] f);
      efrm = f;
      ecnt = ecnt + 8'd1;
      expect_ev(K_FV);
   endtask

   // Stimulus
   initial begin
      repeat (3) @(negedge fs);
      rst = 1'b0;
      idle(2);
      // basic frame
      scan_part(F1, 0, 7);
      complete(F1);
      idle(3);
      // out-of-order index 5 after 0,1,2
      scan_part(FX, 0, 2);
      drive(8'h20, 8'h55);
      expect_ev(K_SEQ);
      scan_part(F2, 0, 7);
      complete(F2);
      // back-to-back frames
      scan_part(F1, 0, 7);
      complete(F1);
      scan_part(F2, 0, 7);
      complete(F2);
      // non-one-hot in CAPT then in IDLE
      scan_part(FX, 0, 1);
      drive(8'h03, 8'hFF);
      expect_ev(K_HOT);
      idle(1);
      drive(8'h03, 8'hFF);
      expect_ev(K_HOT);
      idle(2);
      // index 0 mid-frame restarts capture
      scan_part(FX, 0, 2);
      drive(8'h01, F1[7:0]);
      expect_ev(K_SEQ);
      scan_part(F1, 1, 7);
      complete(F1);
      // five blanks overflow the gap limit
      scan_part(FX, 0, 1);
      idle(5);
      expect_ev(K_GAP);
      // four blanks are tolerated
      scan_part(F2, 0, 1);
      idle(4);
      scan_part(F2, 2, 7);
      complete(F2);
      // 256 frames wrap the counter
      for (int i = 0; i < 256; i++) begin
         if (i % 2 == 0) begin
            scan_part(F1, 0, 7);
            complete(F1);
         end else begin
            scan_part(F2, 0, 7);
            complete(F2);
         end
      end
      idle(4);
      // reset after line 3 is sampled
      scan_part(F1, 0, 3);
      @(posedge fs);
      #1 rst = 1'b1;
      line = 8'h00;
      row  = 8'h00;
      efrm = '0;
      ecnt = '0;
      @(negedge fs);
      #2 rst = 1'b0;
      scan_part(F1, 4, 7);
      idle(4);
      scan_part(F1, 0, 7);
      complete(F1);
      idle(6);
      done = 1'b1;
   end

   // Monitor / scoreboard
   initial begin
      ev_t        e;
      logic [3:0] pul;
      forever begin
         @(negedge fs);
         pul = {gap_err, hot_err, seq_err, frame_valid};
         if (rst) begin
            nvec++;
            if (frame != '0 || pul != '0 || frame_cnt != '0) begin
               nbad++;
               $display("FAIL reset_state: frame=%h pulses=%b cnt=%0d, required all zero",
                        frame, pul, frame_cnt);
            end
         end else begin
            while (sb.size() > 0 && sb[0].cyc < ncyc) begin
               e = sb.pop_front();
               nvec++;
               nbad++;
               $display("FAIL missing_pulse: no pulse at cycle %0d, required pulses=%b",
                        e.cyc, e.kind);
            end
            if (pul != '0 || (sb.size() > 0 && sb[0].cyc == ncyc)) begin
               nvec++;
               if (sb.size() == 0) begin
                  nbad++;
                  $display("FAIL unexpected_pulse: cycle %0d pulses=%b, required none",
                           ncyc, pul);
               end else begin
                  e = sb.pop_front();
                  if (e.cyc != ncyc || pul != e.kind ||
                      frame != e.frm || frame_cnt != e.cnt) begin
                     nbad++;
                     $display("FAIL pulse_check: cyc=%0d pulses=%b frame=%h cnt=%0d, required cyc=%0d pulses=%b frame=%h cnt=%0d",
                              ncyc, pul, frame, frame_cnt,
                              e.cyc, e.kind, e.frm, e.cnt);
                  end
               end
            end
         end
         if (done) begin
            nvec++;
            if (sb.size() != 0) begin
               nbad++;
               $display("FAIL leftover_events: %0d pending, required 0", sb.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
            $finish;
         end
         if (ncyc > 20000) begin
            nbad++;
            $display("FAIL timeout: cycle %0d, required completion", ncyc);
            $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
            $finish;
         end
      end
   end

endmodule
